triangle_feeder: RTL and testbench

//  Supplies triangles to the rasterizer, which consumes vert1/vert2/vert3 with valid_tri.
//  On each frame_start_in pulse it walks a vertex ROM holding NUM_TRIS triangles.
//  For each triangle it reads three consecutive vertex words, assembles them and offers
//  the triangle with a valid/ready handshake.
//  It frames the list with a one-cycle new_frame pulse before the first triangle and a
//  one-cycle obj_done pulse after the last.

---
 rtl/triangle_feeder.sv | 154 +++++++++++++++
 tb/tb_triangle_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_feeder.sv
// Walks a vertex ROM once per frame request and offers each assembled triangle to the
// rasterizer over a valid/ready handshake, bracketed by new_frame and obj_done pulses.
module triangle_feeder #(
   parameter int NUM_TRIS  = 12,
   parameter int VERT_W    = 9,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int MEM_LAT   = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  frame_start_in,
   output logic [ADDR_W-1:0]     vert_addr_out,
   input  logic [3*VERT_W-1:0]   vert_data_in,
   output logic [VERT_W-1:0]     vert1 [2:0],
   output logic [VERT_W-1:0]     vert2 [2:0],
   output logic [VERT_W-1:0]     vert3 [2:0],
   output logic                  valid_tri,
   input  logic                  tri_ready_in,
   output logic                  new_frame,
   output logic                  obj_done,
   output logic                  busy_out
);

   localparam int TW = (NUM_TRIS > 0) ? $clog2(NUM_TRIS + 1) : 1;
   localparam int CW = $clog2(MEM_LAT + 3);
   localparam logic [TW-1:0] LAST_T   = TW'((NUM_TRIS > 0) ? NUM_TRIS - 1 : 0);
   localparam logic [CW-1:0] CAP_LAST = CW'(MEM_LAT + 2);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_NEWF    = 3'd1;
   localparam logic [2:0] S_FETCH   = 3'd2;
   localparam logic [2:0] S_PRESENT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]                     state_q, state_d;
   logic [TW-1:0]                  tri_q, tri_d;
   logic [CW-1:0]                  cyc_q, cyc_d;
   logic [ADDR_W-1:0]              addr_q, addr_d;
   logic [2:0][2:0][VERT_W-1:0]    vert_q, vert_d;
   logic                           valid_q, valid_d;
   logic                           new_frame_q, new_frame_d;
   logic                           obj_done_q, obj_done_d;
   logic                           busy_q, busy_d;

   always_comb begin
      state_d     = state_q;
      tri_d       = tri_q;
      cyc_d       = cyc_q;
      addr_d      = addr_q;
      vert_d      = vert_q;
      valid_d     = 1'b0;
      new_frame_d = 1'b0;
      obj_done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (frame_start_in) begin
               state_d     = S_NEWF;
               new_frame_d = 1'b1;
            end
         end
         S_NEWF: begin
            tri_d = '0;
            if (NUM_TRIS == 0) begin
               state_d    = S_DONE;
               obj_done_d = 1'b1;
            end else begin
               state_d = S_FETCH;
               cyc_d   = '0;
               addr_d  = ADDR_W'(BASE_ADDR);
            end
         end
         S_FETCH: begin
            // cyc_q counts cycles since the first address; word k lands MEM_LAT after address k
            cyc_d = cyc_q + CW'(1);
            if (cyc_q < CW'(2)) begin
               addr_d = addr_q + ADDR_W'(1);
            end
            for (int k = 0; k < 3; k++) begin
               if (cyc_q == CW'(MEM_LAT + k)) begin
                  vert_d[k] = vert_data_in;
               end
            end
            if (cyc_q == CAP_LAST) begin
               state_d = S_PRESENT;
               valid_d = 1'b1;
            end
         end
         S_PRESENT: begin
            if (tri_ready_in) begin
               if (tri_q == LAST_T) begin
                  state_d    = S_DONE;
                  obj_done_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  tri_d   = tri_q + TW'(1);
                  cyc_d   = '0;
                  addr_d  = addr_q + ADDR_W'(1);
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= S_IDLE;
         tri_q       <= '0;
         cyc_q       <= '0;
         addr_q      <= '0;
         vert_q      <= '0;
         valid_q     <= 1'b0;
         new_frame_q <= 1'b0;
         obj_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tri_q       <= tri_d;
         cyc_q       <= cyc_d;
         addr_q      <= addr_d;
         vert_q      <= vert_d;
         valid_q     <= valid_d;
         new_frame_q <= new_frame_d;
         obj_done_q  <= obj_done_d;
         busy_q      <= busy_d;
      end
   end

   assign vert_addr_out = addr_q;
   assign valid_tri     = valid_q;
   assign new_frame     = new_frame_q;
   assign obj_done      = obj_done_q;
   assign busy_out      = busy_q;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_vert_out
         assign vert1[gi] = vert_q[0][gi];
         assign vert2[gi] = vert_q[1][gi];
         assign vert3[gi] = vert_q[2][gi];
      end
   endgenerate

endmodule

// File: tb/tb_triangle_feeder.sv
// Randomized and directed bench for triangle_feeder against a ROM-walk reference model.
module tb_triangle_feeder;

   localparam int NT   = 12;
   localparam int BASE = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // main DUT (12 triangles)
   logic        frame_start, tri_ready;
   logic [7:0]  addr;
   logic [26:0] data;
   logic [8:0]  v1 [2:0];
   logic [8:0]  v2 [2:0];
   logic [8:0]  v3 [2:0];
   logic        valid, new_frame, obj_done, busy;

   // empty-list DUT
   logic        frame_start_z;
   logic [7:0]  addr_z;
   logic [8:0]  vz1 [2:0];
   logic [8:0]  vz2 [2:0];
   logic [8:0]  vz3 [2:0];
   logic        valid_z, nf_z, od_z, busy_z;

   // two-cycle-latency ROM model
   logic [26:0] mem [256];
   logic [26:0] rom_p0, rom_p1;
   always @(posedge clk) begin
      rom_p0 <= mem[addr];
      rom_p1 <= rom_p0;
   end
   assign data = rom_p1;

   triangle_feeder #(.NUM_TRIS(NT), .VERT_W(9), .ADDR_W(8), .BASE_ADDR(BASE), .MEM_LAT(2)) u_dut (
      .clk_in(clk), .rst_in(rst_n), .frame_start_in(frame_start),
      .vert_addr_out(addr), .vert_data_in(data),
      .vert1(v1), .vert2(v2), .vert3(v3),
      .valid_tri(valid), .tri_ready_in(tri_ready),
      .new_frame(new_frame), .obj_done(obj_done), .busy_out(busy)
   );

   triangle_feeder #(.NUM_TRIS(0), .VERT_W(9), .ADDR_W(8), .BASE_ADDR(BASE), .MEM_LAT(2)) u_zero (
      .clk_in(clk), .rst_in(rst_n), .frame_start_in(frame_start_z),
      .vert_addr_out(addr_z), .vert_data_in(27'd0),
      .vert1(vz1), .vert2(vz2), .vert3(vz3),
      .valid_tri(valid_z), .tri_ready_in(1'b1),
      .new_frame(nf_z), .obj_done(od_z), .busy_out(busy_z)
   );

   int tests = 0;
   int fails = 0;
   logic [80:0] got [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [80:0] pack_a();
      return {v3[2], v3[1], v3[0], v2[2], v2[1], v2[0], v1[2], v1[1], v1[0]};
   endfunction

   // triangle t = three consecutive ROM words starting at BASE+3t
   function automatic logic [80:0] exp_tri(int t);
      return {mem[BASE + 3*t + 2], mem[BASE + 3*t + 1], mem[BASE + 3*t]};
   endfunction

   // mode 0: ready always high, 1: random ready, 2: stall 10 cycles from first valid
   task automatic run_frame(input int mode, input bit poke, input int abort_at,
                            output int n_xfer, output int first_valid, output int done_cyc);
      int cyc;
      bit done, poked, prev_valid, prev_xfer, xfer;
      logic [80:0] prev_pack;
      cyc = 0; done = 0; poked = 0; prev_valid = 0; prev_xfer = 0; prev_pack = '0;
      n_xfer = 0; first_valid = -1; done_cyc = -1;
      got.delete();
      frame_start = 1'b1;
      tri_ready = (mode == 0);
      while (!done && cyc < 2000) begin
         tick();
         cyc++;
         frame_start = 1'b0;
         if (cyc == abort_at) return;
         if (poke && !poked && valid) begin
            frame_start = 1'b1;
            poked = 1;
         end
         if (poke && obj_done) frame_start = 1'b1;
         case (mode)
            0: tri_ready = 1'b1;
            1: tri_ready = 1'($urandom_range(0, 1));
            default: tri_ready = (first_valid >= 0) && (cyc >= first_valid + 10);
         endcase
         chk("exclusive", $countones({new_frame, valid, obj_done}) <= 1, 1);
         chk("new_frame", new_frame, cyc == 1);
         chk("busy", busy, 1);
         if (cyc == 2) chk("first_addr", addr, BASE);
         if (prev_valid && !prev_xfer) begin
            chk("hold_valid", valid, 1);
            chk("hold_verts", pack_a(), prev_pack);
         end
         if (prev_xfer) chk("drop_valid", valid, 0);
         if (valid && first_valid < 0) first_valid = cyc;
         xfer = valid && tri_ready;
         if (xfer) begin
            chk($sformatf("tri%0d", n_xfer), pack_a(), exp_tri(n_xfer));
            got.push_back(pack_a());
            n_xfer++;
         end
         if (obj_done) begin
            done = 1;
            done_cyc = cyc;
            chk("xfers_at_done", n_xfer, NT);
         end
         prev_valid = valid;
         prev_xfer = xfer;
         prev_pack = pack_a();
      end
      chk("frame_completed", done, 1);
      tick();
      frame_start = 1'b0;
      tri_ready = 1'b0;
      chk("idle_after_done", {busy, valid, new_frame, obj_done}, 4'b0);
   endtask

   task automatic idle_check(input int n);
      repeat (n) begin
         tick();
         chk("idle_quiet", {busy, valid, new_frame, obj_done}, 4'b0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int nx, fv, dc;
      logic [80:0] t0;
      frame_start = 0; tri_ready = 0; frame_start_z = 0;
      for (int a = 0; a < 256; a++) mem[a] = {9'(a), 9'(a), 9'(a)};

      // reset state
      #2 rst_n = 1'b0;
      tick(); tick();
      chk("rst_addr", addr, 0);
      chk("rst_flags", {valid, new_frame, obj_done, busy}, 4'b0);
      chk("rst_verts", pack_a(), 81'd0);
      chk("rst_zero_dut", {valid_z, nf_z, od_z, busy_z}, 4'b0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // identity ROM, ready always high: exact timing
      run_frame(0, 0, -1, nx, fv, dc);
      chk("f1_first_valid_cycle", fv, 7);
      chk("f1_done_cycle", dc, 74);
      chk("f1_xfers", nx, NT);
      t0 = got[0];
      chk("f1_v1_c0", t0[8:0], 0);
      chk("f1_v2_c0", t0[35:27], 1);
      chk("f1_v3_c0", t0[62:54], 2);
      idle_check(3);

      // 10-cycle back-pressure on the first triangle
      run_frame(2, 0, -1, nx, fv, dc);
      chk("f2_first_valid_cycle", fv, 7);
      chk("f2_done_cycle", dc, 84);
      chk("f2_xfers", nx, NT);
      t0 = got[1];
      chk("f2_t1_v1", t0[8:0], 3);
      chk("f2_t1_v2", t0[35:27], 4);
      chk("f2_t1_v3", t0[62:54], 5);
      idle_check(3);

      // explicit triangle (20,20),(20,40),(40,20) in coords [2:1]
      mem[0] = {9'd20, 9'd20, 9'd0};
      mem[1] = {9'd20, 9'd40, 9'd0};
      mem[2] = {9'd40, 9'd20, 9'd0};
      run_frame(0, 0, -1, nx, fv, dc);
      t0 = got[0];
      chk("f3_v1_x", t0[26:18], 20);
      chk("f3_v1_y", t0[17:9], 20);
      chk("f3_v2_x", t0[53:45], 20);
      chk("f3_v2_y", t0[44:36], 40);
      chk("f3_v3_x", t0[80:72], 40);
      chk("f3_v3_y", t0[71:63], 20);
      chk("f3_done_cycle", dc, 74);
      idle_check(3);

      // random ROM and ready, with stray frame_start in PRESENT and DONE
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 3*NT; a++) mem[BASE + a] = 27'($urandom);
         run_frame(1, 1, -1, nx, fv, dc);
         chk($sformatf("rand%0d_xfers", r), nx, NT);
         idle_check(4);
      end

      // reset while fetching triangle 1, then a clean restart
      for (int a = 0; a < 256; a++) mem[a] = {9'(a), 9'(a), 9'(a)};
      run_frame(0, 0, 10, nx, fv, dc);
      chk("pre_rst_addr", addr, 5);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_addr", addr, 0);
      chk("async_rst_flags", {valid, new_frame, obj_done, busy}, 4'b0);
      chk("async_rst_verts", pack_a(), 81'd0);
      repeat (3) begin
         tick();
         chk("rst_no_done", {obj_done, busy}, 2'b0);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
      run_frame(0, 0, -1, nx, fv, dc);
      chk("restart_first_valid", fv, 7);
      chk("restart_done_cycle", dc, 74);
      chk("restart_xfers", nx, NT);
      idle_check(2);

      // empty triangle list
      frame_start_z = 1'b1;
      tick();
      frame_start_z = 1'b0;
      chk("z_c1", {nf_z, valid_z, od_z, busy_z}, 4'b1001);
      tick();
      chk("z_c2", {nf_z, valid_z, od_z, busy_z}, 4'b0011);
      tick();
      chk("z_c3", {nf_z, valid_z, od_z, busy_z}, 4'b0000);
      tick();
      chk("z_c4", {nf_z, valid_z, od_z, busy_z}, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
